// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset PC, bubble encoding, FSM states and the F/D payload.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_RESET    = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_WORD    = 32'h0000_0000;
  localparam logic [XLEN-1:0] LINK_OFFSET = 32'd8;

  // Next-PC select encodings driven by the branch/jump logic in decode.
  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JREG   = 2'd3
  } npc_sel_t;

  typedef enum logic {
    FETCH_ST = 1'b0,
    HOLD_ST  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fd_payload_t;

  // jal/jalr link value; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] link_addr(input logic [XLEN-1:0] pc);
    return pc + LINK_OFFSET;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// F/D pipeline register: load-enabled, resets to a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  fd_payload_t       fd,
  output logic [XLEN-1:0]   Instr_D,
  output logic [XLEN-1:0]   PC_D,
  output logic              valid_D
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Instr_D <= NOP_INSTR;
      PC_D    <= '0;
      valid_D <= 1'b0;
    end else if (load) begin
      Instr_D <= fd.instr;
      PC_D    <= fd.pc;
      valid_D <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: fetch PC, memory request FSM, one-entry hold buffer and F/D register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PC_RESET,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   nPC,
  input  logic              stall,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              imem_ack,
  output logic [XLEN-1:0]   PC_F,
  output logic [XLEN-1:0]   Instr_D,
  output logic [XLEN-1:0]   PC_D,
  output logic [XLEN-1:0]   PC8_D,
  output logic              valid_D,
  output logic              fetch_busy
);

  fetch_state_t    state;
  logic [XLEN-1:0] hold_word;
  logic            fd_load;
  fd_payload_t     fd_next;

  // Request and address depend only on registered state; busy is the sole ack-dependent output.
  assign imem_req   = (state == FETCH_ST);
  assign imem_addr  = PC_F;
  assign fetch_busy = (state == FETCH_ST) && !imem_ack;

  // F/D advances on an unstalled ack in FETCH, or on stall release in HOLD.
  assign fd_load       = !stall && ((state == HOLD_ST) || imem_ack);
  assign fd_next.instr = (state == HOLD_ST) ? hold_word : imem_rdata;
  assign fd_next.pc    = PC_F;

  // PC register, FSM and hold buffer; ack while in HOLD is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH_ST;
      PC_F      <= RESET_PC;
      hold_word <= '0;
    end else begin
      case (state)
        FETCH_ST: begin
          if (imem_ack) begin
            if (stall) begin
              hold_word <= imem_rdata;
              state     <= HOLD_ST;
            end else begin
              PC_F <= nPC;
            end
          end
        end
        HOLD_ST: begin
          if (!stall) begin
            PC_F  <= nPC;
            state <= FETCH_ST;
          end
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (fd_load),
    .fd      (fd_next),
    .Instr_D (Instr_D),
    .PC_D    (PC_D),
    .valid_D (valid_D)
  );

  assign PC8_D = link_addr(PC_D);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against an in-bench instruction-stream model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] nPC = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack = 1'b0;
  logic [31:0] PC_F, Instr_D, PC_D, PC8_D;
  logic        valid_D, fetch_busy;

  int n_vec = 0;
  int n_err = 0;

  // Model: fetch PC, decode-side instruction, and words parked while stalled.
  logic [31:0] m_pc, m_instr, m_pcd;
  logic        m_valid;
  logic [31:0] held[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .nPC        (nPC),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .PC_F       (PC_F),
    .Instr_D    (Instr_D),
    .PC_D       (PC_D),
    .PC8_D      (PC8_D),
    .valid_D    (valid_D),
    .fetch_busy (fetch_busy)
  );

  // Program image: a distinct word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_3000;
    m_instr = 32'h0;
    m_pcd   = 32'h0;
    m_valid = 1'b0;
    held.delete();
  endtask

  task automatic compare_all();
    chk("imem_req",   32'(imem_req),   32'(held.size() == 0));
    chk("imem_addr",  imem_addr,       m_pc);
    chk("PC_F",       PC_F,            m_pc);
    chk("fetch_busy", 32'(fetch_busy), 32'((held.size() == 0) && !imem_ack));
    chk("Instr_D",    Instr_D,         m_instr);
    chk("PC_D",       PC_D,            m_pcd);
    chk("PC8_D",      PC8_D,           m_pcd + 32'd8);
    chk("valid_D",    32'(valid_D),    32'(m_valid));
  endtask

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic model_step();
    if (held.size() == 0) begin
      if (imem_ack) begin
        if (stall) begin
          held.push_back(mem_word(m_pc));
        end else begin
          m_instr = mem_word(m_pc);
          m_pcd   = m_pc;
          m_valid = 1'b1;
          m_pc    = nPC;
        end
      end
    end else if (!stall) begin
      m_instr = held.pop_front();
      m_pcd   = m_pc;
      m_valid = 1'b1;
      m_pc    = nPC;
    end
  endtask

  // One cycle: drive at negedge, check, step model at posedge, settle.
  task automatic cycle(input bit s, input bit a, input bit jmp, input logic [31:0] tgt);
    @(negedge clk);
    stall    = s;
    imem_ack = a && (held.size() == 0);
    nPC      = jmp ? tgt : m_pc + 32'd4;
    #1 compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Reset asserted mid-cycle; outputs must drop immediately.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    stall    = 1'b0;
    imem_ack = 1'b0;
    #1;
    model_reset();
    chk("rst_PC_F",    PC_F,          32'h0000_3000);
    chk("rst_Instr_D", Instr_D,       32'h0000_0000);
    chk("rst_PC_D",    PC_D,          32'h0000_0000);
    chk("rst_PC8_D",   PC8_D,         32'h0000_0008);
    chk("rst_valid_D", 32'(valid_D),  32'h0);
    chk("rst_req",     32'(imem_req), 32'h1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Zero-wait sequential fetch.
    cycle(0, 1, 0, 0);
    chk("seq_PC8_D_0", PC8_D, 32'h0000_3008);
    cycle(0, 1, 0, 0);
    chk("seq_PC_F",    PC_F,    32'h0000_3008);
    chk("seq_Instr_D", Instr_D, mem_word(32'h0000_3004));
    chk("seq_PC8_D_1", PC8_D,   32'h0000_300C);

    // Memory wait at 0x3008.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    chk("wait_PC_F",    PC_F,    32'h0000_3008);
    chk("wait_Instr_D", Instr_D, mem_word(32'h0000_3004));

    // Stall coinciding with ack: word parks in HOLD, delivered after stall falls.
    cycle(1, 1, 0, 0);
    chk("hold_req", 32'(imem_req), 32'h0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    chk("hold_Instr_D", Instr_D, mem_word(32'h0000_3008));
    chk("hold_PC_F",    PC_F,    32'h0000_300C);

    // Branch target held on nPC while the delay slot waits for memory.
    cycle(0, 0, 1, 32'h0000_3100);
    cycle(0, 0, 1, 32'h0000_3100);
    cycle(0, 1, 1, 32'h0000_3100);
    chk("br_PC_D", PC_D, 32'h0000_300C);
    chk("br_PC_F", PC_F, 32'h0000_3100);

    // Reset while a word sits in HOLD; it must never reach decode.
    cycle(1, 1, 0, 0);
    do_reset();
    cycle(0, 1, 0, 0);
    chk("post_rst_PC_D",    PC_D,    32'h0000_3000);
    chk("post_rst_Instr_D", Instr_D, mem_word(32'h0000_3000));

    // PC8 wrap at the top of the address space.
    cycle(0, 1, 1, 32'hFFFF_FFFC);
    cycle(0, 1, 0, 0);
    chk("wrap_PC_D",  PC_D,  32'hFFFF_FFFC);
    chk("wrap_PC8_D", PC8_D, 32'h0000_0004);

    // Randomized traffic with occasional branches and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        bit          s, a, j;
        logic [31:0] t;
        s = ($urandom_range(0, 3) == 0);
        a = ($urandom_range(0, 9) < 7);
        j = ($urandom_range(0, 9) == 0);
        t = $urandom;
        if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
        cycle(s, a, j, t);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
